// File: rtl/uart_result_tx_ctrl.sv
// Drains result words to the host UART: buffers them in a FIFO, prefixes each frame of
// OUT_SIZE words with a header byte and sends every word LSB first, paced by tx_finish.
module uart_result_tx_ctrl #(
  parameter int          D_WL       = 24,
  parameter int          OUT_SIZE   = 26,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            res_valid,
  input  logic [D_WL-1:0] res_data,
  output logic            res_ready,
  output logic [7:0]      tx_data,
  output logic            tx_en,
  input  logic            tx_finish,
  output logic            frame_done,
  output logic            busy,
  output logic            overflow
);

  localparam int NBYTES = D_WL / 8;
  localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int WC_W   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(NBYTES - 1);
  localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(OUT_SIZE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_WAIT_H, S_LOAD, S_SEND, S_WAIT_B
  } state_e;

  state_e state_q, state_d;

  // ---------------- result FIFO ----------------
  logic [D_WL-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push, pop, fifo_empty;

  assign res_ready  = (count_q != FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign push       = res_valid & res_ready;
  assign pop        = (state_q == S_LOAD);

  // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= res_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                        overflow <= 1'b0;
    else if (res_valid & ~res_ready) overflow <= 1'b1;
  end

  // ---------------- tx_finish edge detect ----------------
  logic tx_finish_prev_q;
  logic fin_rise;

  always_ff @(posedge clk) begin
    if (rst) tx_finish_prev_q <= 1'b0;
    else     tx_finish_prev_q <= tx_finish;
  end

  assign fin_rise = tx_finish & ~tx_finish_prev_q;

  // ---------------- FSM: state register ----------------
  // NOTE: every clocked assignment uses <= so all registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  logic [D_WL-1:0] sh_q, sh_d;
  logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [WC_W-1:0] word_cnt_q, word_cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_en_q, tx_en_d;
  logic            frame_done_q, frame_done_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (!fifo_empty) state_d = (word_cnt_q == '0) ? S_HDR : S_LOAD;
      S_HDR:    state_d = S_WAIT_H;
      S_WAIT_H: if (fin_rise) state_d = S_LOAD;
      S_LOAD:   state_d = S_SEND;
      S_SEND:   state_d = S_WAIT_B;
      S_WAIT_B: if (fin_rise) state_d = (byte_cnt_q != LAST_BYTE) ? S_SEND : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs and datapath ----------------
  // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
  always_comb begin
    tx_data_d    = tx_data_q;
    tx_en_d      = 1'b0;
    frame_done_d = 1'b0;
    sh_d         = sh_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    unique case (state_q)
      S_HDR: begin
        tx_data_d = HEADER;
        tx_en_d   = 1'b1;
      end
      S_LOAD: begin
        sh_d       = mem_q[rd_ptr_q];
        byte_cnt_d = '0;
      end
      S_SEND: begin
        tx_data_d = sh_q[7:0];
        tx_en_d   = 1'b1;
      end
      S_WAIT_B: begin
        if (fin_rise) begin
          if (byte_cnt_q != LAST_BYTE) begin
            sh_d       = sh_q >> 8;
            byte_cnt_d = byte_cnt_q + 1'b1;
          end else if (word_cnt_q == LAST_WORD) begin
            word_cnt_d   = '0;
            frame_done_d = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q    <= '0;
      tx_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      sh_q         <= '0;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
    end else begin
      tx_data_q    <= tx_data_d;
      tx_en_q      <= tx_en_d;
      frame_done_q <= frame_done_d;
      sh_q         <= sh_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_en      = tx_en_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_result_tx_ctrl.sv
// Self-checking bench for uart_result_tx_ctrl: a scoreboard of expected UART bytes is filled
// as words are accepted and drained as tx_en pulses appear; a small UART model answers tx_en.
module tb_uart_result_tx_ctrl;

  localparam int D_WL       = 24;
  localparam int OUT_SIZE   = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int NB         = D_WL / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            res_valid;
  logic [D_WL-1:0] res_data;
  logic            res_ready;
  logic [7:0]      tx_data;
  logic            tx_en;
  logic            tx_finish;
  logic            frame_done;
  logic            busy;
  logic            overflow;

  uart_result_tx_ctrl #(
    .D_WL(D_WL), .OUT_SIZE(OUT_SIZE), .FIFO_DEPTH(FIFO_DEPTH), .HEADER(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .tx_data(tx_data), .tx_en(tx_en), .tx_finish(tx_finish), .frame_done(frame_done),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; bit mid; } exp_t;
  typedef struct { logic [7:0] b; int gap;  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];

  int checks_total  = 0;
  int checks_passed = 0;
  int cyc           = 0;
  int rise_cyc      = 0;
  int tx_en_cnt     = 0;
  int fd_cnt        = 0;
  int fd_cyc        = 0;
  int tb_word_cnt   = 0;
  bit stall         = 1'b0;
  bit hold_high     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: drops tx_finish for a few cycles per byte, optionally stalled or stuck high.
  initial begin
    tx_finish = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_en && !hold_high) begin
        tx_finish = 1'b0;
        repeat (3) @(negedge clk);
        while (stall) @(negedge clk);
        tx_finish = 1'b1;
        rise_cyc  = cyc;
      end
    end
  end

  // Output monitor
  initial begin
    forever begin
      @(negedge clk);
      if (tx_en) begin
        obs_q.push_back('{b: tx_data, gap: cyc - rise_cyc});
        tx_en_cnt++;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic push_expected(input logic [D_WL-1:0] w);
    if (tb_word_cnt == 0) exp_q.push_back('{b: 8'hA5, mid: 1'b0});
    for (int i = 0; i < NB; i++) exp_q.push_back('{b: w[8*i +: 8], mid: (i != 0)});
    tb_word_cnt = (tb_word_cnt + 1) % OUT_SIZE;
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic send_word(input logic [D_WL-1:0] w, input bit keep, output bit acc);
    res_valid = 1'b1;
    res_data  = w;
    acc       = res_ready;
    if (acc) push_expected(w);
    @(negedge clk);
    if (!keep) res_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    res_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    tb_word_cnt = 0;
  endtask

  task automatic drain(input string name);
    exp_t e;
    obs_t o;
    int   waited;
    while (exp_q.size() > 0) begin
      waited = 0;
      while (obs_q.size() == 0 && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      e = exp_q.pop_front();
      checks_total++;
      if (obs_q.size() == 0) begin
        $display("FAIL %s_timeout: no tx_en in %0d cycles, want byte %h", name, waited, e.b);
        exp_q.delete();
      end else begin
        o = obs_q.pop_front();
        if (o.b !== e.b) $display("FAIL %s_byte: got %h want %h", name, o.b, e.b);
        else checks_passed++;
        if (e.mid) begin
          checks_total++;
          if (o.gap != 2) $display("FAIL %s_gap: fin_rise->tx_en got %0d want 2", name, o.gap);
          else checks_passed++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    res_valid = 1'b0;
    res_data  = '0;
    repeat (2) @(negedge clk);
    checks_total += 6;
    if (tx_en !== 1'b0)      $display("FAIL reset_tx_en: got %b want 0", tx_en);           else checks_passed++;
    if (tx_data !== 8'h00)   $display("FAIL reset_tx_data: got %h want 00", tx_data);      else checks_passed++;
    if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else checks_passed++;
    if (overflow !== 1'b0)   $display("FAIL reset_overflow: got %b want 0", overflow);     else checks_passed++;
    if (res_ready !== 1'b1)  $display("FAIL reset_res_ready: got %b want 1", res_ready);   else checks_passed++;
    if (busy !== 1'b0)       $display("FAIL reset_busy: got %b want 0", busy);             else checks_passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_word();
    bit acc;
    send_word(24'h123456, 1'b0, acc);
    checks_total += 4;
    if (acc !== 1'b1) $display("FAIL single_accept: got %b want 1", acc); else checks_passed++;
    if (tx_en !== 1'b0) $display("FAIL single_lat_t1: tx_en got %b want 0", tx_en); else checks_passed++;
    @(negedge clk);
    if (tx_en !== 1'b0) $display("FAIL single_lat_t2: tx_en got %b want 0", tx_en); else checks_passed++;
    @(negedge clk);
    if (tx_en !== 1'b1 || tx_data !== 8'hA5)
      $display("FAIL single_lat_t3: tx_en/tx_data got %b/%h want 1/a5", tx_en, tx_data);
    else checks_passed++;
    drain("single");
    repeat (10) @(negedge clk);
    checks_total += 2;
    if (fd_cnt != 0) $display("FAIL single_no_frame_done: got %0d pulses want 0", fd_cnt); else checks_passed++;
    if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", busy); else checks_passed++;
  endtask

  task automatic test_frame_complete();
    bit acc;
    send_word(24'hABCDEF, 1'b0, acc);
    drain("frame");
    repeat (10) @(negedge clk);
    checks_total += 3;
    if (fd_cnt != 1) $display("FAIL frame_done_count: got %0d want 1", fd_cnt); else checks_passed++;
    if (fd_cyc - rise_cyc != 1)
      $display("FAIL frame_done_timing: fin_rise->frame_done got %0d want 1", fd_cyc - rise_cyc);
    else checks_passed++;
    if (busy !== 1'b0) $display("FAIL frame_idle_busy: got %b want 0", busy); else checks_passed++;
  endtask

  task automatic test_overflow();
    bit       acc;
    bit [5:0] acc_vec;
    int       fd_before = fd_cnt;
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_word(24'h100000 + 24'(i * 24'h010203), 1'b1, acc);
      acc_vec[i] = acc;
    end
    res_valid = 1'b0;
    checks_total += 3;
    if (acc_vec !== 6'b001111) $display("FAIL ovf_accept_pattern: got %b want 001111", acc_vec); else checks_passed++;
    if (res_ready !== 1'b0) $display("FAIL ovf_res_ready: got %b want 0", res_ready); else checks_passed++;
    if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else checks_passed++;
    repeat (5) @(negedge clk);
    stall = 1'b0;
    drain("ovf");
    repeat (10) @(negedge clk);
    checks_total += 2;
    if (fd_cnt - fd_before != 2) $display("FAIL ovf_frames: got %0d want 2", fd_cnt - fd_before); else checks_passed++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else checks_passed++;
  endtask

  task automatic test_no_rise();
    bit acc;
    int en_before = tx_en_cnt;
    hold_high = 1'b1;
    obs_q.delete();
    send_word(24'h0F0F0F, 1'b0, acc);
    repeat (30) @(negedge clk);
    checks_total += 3;
    if (tx_en_cnt - en_before != 1) $display("FAIL norise_tx_en_count: got %0d want 1", tx_en_cnt - en_before); else checks_passed++;
    if (obs_q.size() != 1 || obs_q[0].b !== 8'hA5)
      $display("FAIL norise_header: got %0d bytes want 1 byte a5", obs_q.size());
    else checks_passed++;
    if (busy !== 1'b1) $display("FAIL norise_busy: got %b want 1", busy); else checks_passed++;
    hold_high = 1'b0;
    apply_reset();
    checks_total += 2;
    if (overflow !== 1'b0) $display("FAIL norise_ovf_cleared: got %b want 0", overflow); else checks_passed++;
    if (busy !== 1'b0) $display("FAIL norise_busy_cleared: got %b want 0", busy); else checks_passed++;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    bit acc;
    int waited = 0;
    send_word(24'h13579B, 1'b1, acc);
    send_word(24'h2468AC, 1'b0, acc);
    while (obs_q.size() < 3 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks_total++;
    if (obs_q.size() < 3) $display("FAIL rstmid_prefix_timeout: got %0d bytes want 3", obs_q.size());
    else if (obs_q[0].b !== 8'hA5 || obs_q[1].b !== 8'h9B || obs_q[2].b !== 8'h57)
      $display("FAIL rstmid_prefix: got %h %h %h want a5 9b 57", obs_q[0].b, obs_q[1].b, obs_q[2].b);
    else checks_passed++;
    rst = 1'b1;
    @(negedge clk);
    checks_total += 3;
    if (tx_en !== 1'b0)     $display("FAIL rstmid_tx_en: got %b want 0", tx_en);         else checks_passed++;
    if (busy !== 1'b0)      $display("FAIL rstmid_busy: got %b want 0", busy);           else checks_passed++;
    if (res_ready !== 1'b1) $display("FAIL rstmid_res_ready: got %b want 1", res_ready); else checks_passed++;
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    tb_word_cnt = 0;
    repeat (20) @(negedge clk);
    checks_total++;
    if (obs_q.size() != 0) $display("FAIL rstmid_abandon: got %0d stray bytes want 0", obs_q.size()); else checks_passed++;
    send_word(24'hC0FFEE, 1'b0, acc);
    drain("rstmid_after");
    repeat (10) @(negedge clk);
  endtask

  task automatic test_simul_push_pop();
    bit acc;
    apply_reset();
    repeat (3) @(negedge clk);
    stall = 1'b1;
    send_word(24'h111111, 1'b1, acc);
    send_word(24'h222222, 1'b1, acc);
    send_word(24'h333333, 1'b0, acc);
    repeat (10) @(negedge clk);
    checks_total++;
    if (res_ready !== 1'b1) $display("FAIL simul_pre_ready: got %b want 1", res_ready); else checks_passed++;
    @(posedge clk);
    stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    send_word(24'h444444, 1'b1, acc);
    checks_total += 2;
    if (acc !== 1'b1) $display("FAIL simul_accept: got %b want 1", acc); else checks_passed++;
    if (res_ready !== 1'b1) $display("FAIL simul_count_kept: res_ready got %b want 1", res_ready); else checks_passed++;
    send_word(24'h555555, 1'b0, acc);
    checks_total += 2;
    if (acc !== 1'b1) $display("FAIL simul_accept_last: got %b want 1", acc); else checks_passed++;
    if (res_ready !== 1'b0) $display("FAIL simul_full: res_ready got %b want 0", res_ready); else checks_passed++;
    drain("simul");
    repeat (10) @(negedge clk);
    checks_total++;
    if (obs_q.size() != 0) $display("FAIL simul_extra: got %0d extra bytes want 0", obs_q.size()); else checks_passed++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_frame_complete();
    test_overflow();
    test_no_rise();
    test_reset_mid_frame();
    test_simul_push_pop();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
